// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: opcode encodings, FSM states,
// fault codes and the conditional-branch decision.
package fetch_sequencer_pkg;

   localparam int OPCODE_W = 5;

   localparam logic [OPCODE_W-1:0] OP_BEQ  = 5'b01011;
   localparam logic [OPCODE_W-1:0] OP_BNE  = 5'b01100;
   localparam logic [OPCODE_W-1:0] OP_JMP  = 5'b01101;
   localparam logic [OPCODE_W-1:0] OP_CALL = 5'b01110;
   localparam logic [OPCODE_W-1:0] OP_RET  = 5'b01111;

   localparam logic [1:0] FAULT_NONE      = 2'b00;
   localparam logic [1:0] FAULT_OVERFLOW  = 2'b01;
   localparam logic [1:0] FAULT_UNDERFLOW = 2'b10;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_e;

   // Only BEQ/BNE are conditional; a branch strobe with any other opcode falls through.
   function automatic logic branch_taken(input logic [OPCODE_W-1:0] op, input logic zero);
      return ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
   endfunction

endpackage

// File: rtl/fetch_sequencer_ras.sv
// Hardware return-address stack. The pointer carries one extra bit so that
// full (sp == STACK_DEPTH) and empty (sp == 0) are distinct states.
module ras_stack #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              full,
   output logic              empty
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]  sp_q, sp_d;
   logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
   logic [IDX_W-1:0]  top_idx;

   assign full    = (sp_q == PTR_W'(STACK_DEPTH));
   assign empty   = (sp_q == '0);
   assign top_idx = IDX_W'(sp_q - PTR_W'(1));
   assign top     = mem_q[top_idx];

   always_comb begin
      sp_d = sp_q;
      if (push && !full)
         sp_d = sp_q + PTR_W'(1);
      else if (pop && !empty)
         sp_d = sp_q - PTR_W'(1);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sp_q <= '0;
      else
         sp_q <= sp_d;
   end

   // NOTE: entries are not reset; sp alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem_q[sp_q[IDX_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Non-pipelined instruction fetch/issue sequencer: owns the PC, fetches one word
// at a time, issues it, and resolves branch/jump/call/ret on accept.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int                ADDR_W      = 8,
   parameter int                INSTR_W     = 32,
   parameter int                STACK_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                imem_valid,
   output logic [INSTR_W-1:0]  instr,
   output logic [OPCODE_W-1:0] opcode,
   output logic                instr_valid,
   input  logic                instr_ready,
   input  logic                branch,
   input  logic                jump,
   input  logic                call,
   input  logic                ret,
   input  logic                zero_flag,
   input  logic [ADDR_W-1:0]   target_addr,
   output logic [ADDR_W-1:0]   pc,
   output logic                halted,
   output logic [1:0]          fault_code
);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [1:0]           fault_q, fault_d;
   logic [ADDR_W-1:0]    pc_plus1;
   logic                 accept;
   logic                 ras_push, ras_pop, ras_full, ras_empty;
   logic [ADDR_W-1:0]    ras_top;

   assign pc_plus1    = pc_q + ADDR_W'(1);
   assign accept      = (state_q == S_ISSUE) && instr_ready;

   // The reset state is S_FETCH, so the request is gated by rst_n to stay low while in reset.
   assign imem_req    = rst_n && (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[INSTR_W-1 -: OPCODE_W];
   assign instr_valid = (state_q == S_ISSUE);
   assign pc          = pc_q;
   assign halted      = (state_q == S_HALT);
   assign fault_code  = fault_q;

   ras_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus1),
      .top       (ras_top),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      fault_d  = fault_q;
      ras_push = 1'b0;
      ras_pop  = 1'b0;

      case (state_q)
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            if (imem_valid) begin
               instr_d = imem_rdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (accept) begin
               state_d = S_FETCH;
               pc_d    = pc_plus1;
               if (ret) begin
                  if (ras_empty) begin
                     pc_d    = pc_q;
                     fault_d = FAULT_UNDERFLOW;
                     state_d = S_HALT;
                  end else begin
                     ras_pop = 1'b1;
                     pc_d    = ras_top;
                  end
               end else if (call) begin
                  if (ras_full) begin
                     pc_d    = pc_q;
                     fault_d = FAULT_OVERFLOW;
                     state_d = S_HALT;
                  end else begin
                     ras_push = 1'b1;
                     pc_d     = target_addr;
                  end
               end else if (jump) begin
                  pc_d = target_addr;
               end else if (branch && branch_taken(opcode, zero_flag)) begin
                  pc_d = target_addr;
               end
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         fault_q <= FAULT_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         fault_q <= fault_d;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: an imem responder, a fetch-address
// scoreboard fed by a reference next-PC model, and one task per scenario.
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   localparam int          ADDR_W   = 8;
   localparam int          INSTR_W  = 32;
   localparam int          DEPTH    = 8;
   localparam logic [7:0]  RESET_PC = 8'h00;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata = '0;
   logic               imem_valid = 1'b0;
   logic [INSTR_W-1:0] instr;
   logic [4:0]         opcode;
   logic               instr_valid;
   logic               instr_ready = 1'b0;
   logic               branch = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
   logic               zero_flag = 1'b0;
   logic [ADDR_W-1:0]  target_addr = '0;
   logic [ADDR_W-1:0]  pc;
   logic               halted;
   logic [1:0]         fault_code;

   fetch_sequencer #(
      .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .STACK_DEPTH(DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .branch(branch), .jump(jump), .call(call), .ret(ret),
      .zero_flag(zero_flag), .target_addr(target_addr),
      .pc(pc), .halted(halted), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc = 0;
   logic [31:0] mem [256];
   logic [7:0]  exp_q [$];
   logic [7:0]  model_stack [$];
   logic [7:0]  model_pc = RESET_PC;
   logic [1:0]  model_fault = 2'b00;
   logic [7:0]  exp_addr;
   int          stale_cnt = 0;
   int          stale_done = 0;
   logic        pend = 1'b0;
   logic [7:0]  pend_addr = '0;

   always @(posedge clk) cyc++;

   // Instruction memory: answers one cycle after each request; can inject a stale pulse.
   always @(negedge clk) begin
      imem_valid = 1'b0;
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (stale_cnt != stale_done) begin
            imem_valid = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            stale_done = stale_cnt;
         end
         if (pend) begin
            imem_valid = 1'b1;
            imem_rdata = mem[pend_addr];
            pend       = 1'b0;
         end
         if (imem_req) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
         end
      end
   end

   // Fetch-address scoreboard.
   always @(negedge clk) begin
      if (rst_n && imem_req) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL fetch_addr: unexpected imem_req at addr %02h", imem_addr);
         end else begin
            exp_addr = exp_q.pop_front();
            if (imem_addr !== exp_addr) begin
               tests_failed++;
               $display("FAIL fetch_addr: got %02h expected %02h", imem_addr, exp_addr);
            end
         end
      end
   end

   task automatic init_mem();
      for (int i = 0; i < 256; i++)
         mem[i] = {5'(i % 8), 27'(i * 40503 + 17)};
   endtask

   task automatic set_op(input logic [7:0] a, input logic [4:0] op);
      mem[a][31:27] = op;
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      instr_ready = 1'b0; branch = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
      zero_flag = 1'b0; target_addr = '0;
      exp_q.delete();
      model_stack.delete();
      model_pc    = RESET_PC;
      model_fault = 2'b00;
      exp_q.push_back(RESET_PC);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic drain();
      repeat (4) @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: %0d expected fetches never seen, next %02h", exp_q.size(), exp_q[0]);
      end
   endtask

   // Waits for an issued instruction, checks it, optionally back-pressures, then accepts it.
   task automatic issue(input logic br, input logic jp, input logic cl, input logic rt,
                        input logic zf, input logic [7:0] tgt, input int hold);
      int          n;
      logic [31:0] held;
      logic [4:0]  op;
      logic [7:0]  nxt;
      logic        bad;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!instr_valid && n < 40);
      tests_run++;
      if (instr_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL issue_timeout: instr_valid=%b at model pc %02h after %0d cycles",
                  instr_valid, model_pc, n);
         return;
      end
      tests_run++;
      if (instr !== mem[model_pc]) begin
         tests_failed++;
         $display("FAIL issue_instr: got %08h expected %08h", instr, mem[model_pc]);
      end
      tests_run++;
      if (opcode !== mem[model_pc][31:27]) begin
         tests_failed++;
         $display("FAIL issue_opcode: got %05b expected %05b", opcode, mem[model_pc][31:27]);
      end
      tests_run++;
      if (pc !== model_pc) begin
         tests_failed++;
         $display("FAIL issue_pc: got %02h expected %02h", pc, model_pc);
      end
      if (hold > 0) begin
         held = instr;
         bad  = 1'b0;
         repeat (hold) begin
            @(negedge clk);
            if (instr_valid !== 1'b1 || instr !== held || imem_req !== 1'b0) bad = 1'b1;
         end
         tests_run++;
         if (bad) begin
            tests_failed++;
            $display("FAIL backpressure_hold: valid=%b instr=%08h expected held %08h, req=%b",
                     instr_valid, instr, held, imem_req);
         end
      end
      op  = mem[model_pc][31:27];
      nxt = model_pc + 8'd1;
      if (rt) begin
         if (model_stack.size() == 0) model_fault = FAULT_UNDERFLOW;
         else nxt = model_stack.pop_back();
      end else if (cl) begin
         if (model_stack.size() == DEPTH) model_fault = FAULT_OVERFLOW;
         else begin
            model_stack.push_back(model_pc + 8'd1);
            nxt = tgt;
         end
      end else if (jp) begin
         nxt = tgt;
      end else if (br && ((op == OP_BEQ && zf) || (op == OP_BNE && !zf))) begin
         nxt = tgt;
      end
      if (model_fault == FAULT_NONE) begin
         exp_q.push_back(nxt);
         model_pc = nxt;
      end
      branch = br; jump = jp; call = cl; ret = rt; zero_flag = zf; target_addr = tgt;
      instr_ready = 1'b1;
      @(posedge clk);
      #1;
      instr_ready = 1'b0; branch = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; zero_flag = 1'b0;
   endtask

   task automatic plain();
      issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
   endtask

   task automatic test_reset();
      init_mem();
      assert_reset();
      #3;
      tests_run++;
      if ({imem_req, instr_valid, halted} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_ctrl: req/valid/halted=%b expected 000", {imem_req, instr_valid, halted});
      end
      tests_run++;
      if (instr !== 32'h0 || fault_code !== 2'b00 || pc !== RESET_PC) begin
         tests_failed++;
         $display("FAIL reset_regs: instr=%08h fault=%b pc=%02h expected 0/00/%02h",
                  instr, fault_code, pc, RESET_PC);
      end
      release_reset();
      drain();
   endtask

   task automatic test_sequential();
      int last;
      init_mem();
      assert_reset();
      release_reset();
      last = 0;
      for (int i = 0; i < 4; i++) begin
         plain();
         if (i > 0) begin
            tests_run++;
            if (cyc - last != 3) begin
               tests_failed++;
               $display("FAIL seq_latency: %0d cycles between issues, expected 3", cyc - last);
            end
         end
         last = cyc;
      end
      drain();
   endtask

   task automatic test_branch();
      init_mem();
      set_op(8'h00, OP_BEQ);
      set_op(8'h40, OP_BEQ);
      set_op(8'h41, OP_BNE);
      set_op(8'h51, OP_BNE);
      set_op(8'h52, OP_JMP);
      assert_reset();
      release_reset();
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 0);  // BEQ taken
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h70, 0);  // BEQ not taken
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h50, 0);  // BNE taken
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h70, 0);  // other opcode: never taken
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h70, 0);  // BNE not taken
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h60, 0);  // jump
      drain();
   endtask

   task automatic test_call_ret();
      init_mem();
      set_op(8'h05, OP_CALL);
      set_op(8'h22, OP_RET);
      assert_reset();
      release_reset();
      repeat (5) plain();
      issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 0);
      plain();
      plain();
      issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 0);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 0);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h50, 0);
      repeat (3) issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
      drain();
   endtask

   task automatic test_overflow();
      init_mem();
      assert_reset();
      release_reset();
      for (int k = 0; k <= DEPTH; k++)
         issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'((k + 1) * 16), 0);
      tests_run++;
      if (halted !== 1'b1 || fault_code !== FAULT_OVERFLOW || pc !== 8'h80 || instr_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL overflow: halted=%b fault=%b pc=%02h valid=%b expected 1/01/80/0",
                  halted, fault_code, pc, instr_valid);
      end
      repeat (10) @(negedge clk);
      tests_run++;
      if (halted !== 1'b1 || fault_code !== FAULT_OVERFLOW || pc !== 8'h80) begin
         tests_failed++;
         $display("FAIL overflow_sticky: halted=%b fault=%b pc=%02h", halted, fault_code, pc);
      end
      drain();
   endtask

   task automatic test_underflow();
      init_mem();
      set_op(8'h00, OP_RET);
      assert_reset();
      release_reset();
      issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
      repeat (5) @(negedge clk);
      tests_run++;
      if (halted !== 1'b1 || fault_code !== FAULT_UNDERFLOW || pc !== 8'h00 || instr_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL underflow: halted=%b fault=%b pc=%02h valid=%b expected 1/10/00/0",
                  halted, fault_code, pc, instr_valid);
      end
      drain();
   endtask

   task automatic test_backpressure_wrap();
      init_mem();
      assert_reset();
      release_reset();
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 0);
      issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10);
      plain();
      drain();
      tests_run++;
      if (halted !== 1'b0 || fault_code !== FAULT_NONE) begin
         tests_failed++;
         $display("FAIL wrap_no_fault: halted=%b fault=%b expected 0/00", halted, fault_code);
      end
   endtask

   task automatic test_reset_mid_wait();
      init_mem();
      assert_reset();
      release_reset();
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 0);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
          fault_code !== 2'b00 || pc !== RESET_PC) begin
         tests_failed++;
         $display("FAIL async_reset: req=%b valid=%b halted=%b fault=%b pc=%02h expected 0/0/0/00/%02h",
                  imem_req, instr_valid, halted, fault_code, pc, RESET_PC);
      end
      assert_reset();
      release_reset();
      stale_cnt++;
      plain();
      drain();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_backpressure_wrap();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", tests_failed);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-side partner of the opcode decoder.
- Owns the program counter, fetches words from instruction memory, and issues one instruction at a time to the decode/execute stage.
- Consumes that stage's branch/jump/call/ret controls to compute the next PC, and maintains a hardware return-address stack.
- Multi-cycle and non-pipelined: at most one instruction is in flight.

Parameters:
- ADDR_W, 8: PC and instruction-memory address width.
- INSTR_W, 32: instruction width; opcode is instr[INSTR_W-1 -: 5].
- STACK_DEPTH, 8: return-address stack entries (power of 2, ≥2).
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  one-cycle fetch request pulse.
- imem_addr  out  ADDR_W  fetch address; valid while imem_req=1.
- imem_rdata  in  INSTR_W  fetched word; valid when imem_valid=1.
- imem_valid  in  1  fetch response; arrives ≥1 cycle after imem_req.
- instr  out  INSTR_W  issued instruction word.
- opcode  out  5  opcode field of instr.
- instr_valid  out  1  instr/opcode valid.
- instr_ready  in  1  execute stage accepts; accept = instr_valid & instr_ready.
- branch, jump, call, ret  in  1 each  decoder controls for the issued instruction; sampled only on accept.
- zero_flag  in  1  ALU zero result for the issued instruction; sampled on accept.
- target_addr  in  ADDR_W  branch/jump/call target; sampled on accept.
- pc  out  ADDR_W  address of the current or issued instruction.
- halted  out  1  sticky fault indication.
- fault_code  out  2  00 none, 01 stack overflow, 10 stack underflow.

Behaviour:
- Reset is asynchronous active-low on rst_n; one clock, clk.
- Reset values:
  - pc=RESET_PC, state=S_FETCH.
  - Stack empty, sp=0.
  - imem_req=0, instr_valid=0, instr=0, halted=0, fault_code=00.
- States: S_FETCH, S_WAIT, S_ISSUE, S_HALT.
- S_FETCH: drive imem_req=1 and imem_addr=pc for exactly one cycle, then go to S_WAIT.
- S_WAIT:
  - On imem_valid, register imem_rdata into instr and go to S_ISSUE.
  - imem_valid in any other state is ignored, including a stale response after reset.
- S_ISSUE:
  - instr_valid=1; instr and opcode stay stable until accept.
  - On accept, compute next_pc, go to S_FETCH, and set instr_valid=0 in the following cycle.
- next_pc priority, applied on accept:
  1. ret:
     - If stack empty: underflow; pc unchanged; halted=1, fault_code=10, go to S_HALT.
     - Otherwise pop; next_pc = popped entry.
  2. call:
     - If stack full (STACK_DEPTH entries): overflow; no push; halted=1, fault_code=01, go to S_HALT.
     - Otherwise push pc+1 and set next_pc = target_addr.
  3. jump: next_pc = target_addr.
  4. branch with opcode 01011 (BEQ): taken iff zero_flag=1.
  5. branch with opcode 01100 (BNE): taken iff zero_flag=0.
     - Taken: next_pc = target_addr; not taken: pc+1.
  6. branch asserted with any other opcode: treated as not taken.
  7. Otherwise: next_pc = pc+1.
- PC arithmetic: pc+1 wraps modulo 2^ADDR_W, from all-ones to 0; this is not a fault.
- Stack: a pushed return address of pc+1 also wraps.
- Fetch latency: minimum 3 cycles per instruction (FETCH, WAIT with response in the next cycle, ISSUE with instr_ready=1).
- Back-pressure: instr_ready=0 holds S_ISSUE indefinitely; no state changes.
- S_HALT:
  - imem_req=0, instr_valid=0; pc holds the faulting instruction's address.
  - Exit only via reset.
- Reset mid-operation (any state): immediate asynchronous return to reset values; an outstanding fetch is abandoned.

Decomposition:
- Shared package:
  - Opcode constants: OP_BEQ=5'b01011, OP_BNE=5'b01100, OP_JMP=5'b01101, OP_CALL=5'b01110, OP_RET=5'b01111.
  - State enum for S_FETCH/S_WAIT/S_ISSUE/S_HALT.
  - Fault-code constants.
- Sub-module `ras_stack`:
  - Parameters: ADDR_W and STACK_DEPTH.
  - Interface: push/pop/push_data/top/full/empty.
  - Pointer of clog2(STACK_DEPTH)+1 bits; same async reset.

Test Plan:
- Sequential fetch: imem responds 1 cycle after req, instr_ready=1, no controls → pc goes 0,1,2,3 with one issue every 3 cycles; opcode equals instr[31:27].
- BEQ/BNE: opcode 01011, branch=1, zero_flag=1, target=0x40 → next imem_addr=0x40. Repeat with zero_flag=0 → next address pc+1. Opcode 01100 with zero_flag=0 → 0x40.
- Call/return: at pc=0x05, call with target=0x20; later ret at pc=0x22 → fetches go to 0x20 then 0x06. Nested calls 3 deep return in LIFO order.
- Stack faults:
  - STACK_DEPTH+1 consecutive calls → last call gives halted=1, fault_code=01, no further imem_req.
  - After reset, ret with stack empty → fault_code=10.
- Back-pressure and wrap: hold instr_ready=0 for 10 cycles → instr_valid stays 1 with instr stable and no imem_req. Then at pc=0xFF with no control → next fetch at 0x00 and halted stays 0.
- Async reset mid-WAIT: assert rst_n=0 between edges → outputs clear immediately. A late imem_valid after release is ignored; the first fetch after release is at RESET_PC.
